// File: rtl/repair_packet_gen.sv
// Rename-map repair sequencer: after a recovery request, streams the whole
// architectural map into the rename map as registered N_PACKETS-wide write packets.
module repair_packet_gen #(
  parameter int DEPTH     = 32,
  parameter int INDEX     = 5,
  parameter int WIDTH     = 7,
  parameter int N_PACKETS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recoverFlag_i,
  output logic [INDEX-1:0] amtAddr_o    [0:N_PACKETS-1],
  input  logic [WIDTH-1:0] amtData_i    [0:N_PACKETS-1],
  output logic             repairFlag_o,
  output logic [INDEX-1:0] repairAddr_o [0:N_PACKETS-1],
  output logic [WIDTH-1:0] repairData_o [0:N_PACKETS-1],
  output logic             repairBusy_o,
  output logic             repairDone_o,
  output logic [1:0]       dbg_state_o
);

  localparam int P  = (DEPTH + N_PACKETS - 1) / N_PACKETS;
  localparam int BW = INDEX + 1;
  localparam logic [BW-1:0] LAST     = BW'(DEPTH - 1);
  localparam logic [BW-1:0] STEP     = BW'(N_PACKETS);
  localparam logic [BW-1:0] CNT_LAST = BW'(P - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [BW-1:0]    r_base;
  logic [BW-1:0]    r_pkt_cnt;
  logic             r_flag;
  logic             r_busy;
  logic             r_done;
  logic [INDEX-1:0] r_addr [0:N_PACKETS-1];
  logic [WIDTH-1:0] r_data [0:N_PACKETS-1];

  logic [BW-1:0]    w_sum      [0:N_PACKETS-1];
  logic [INDEX-1:0] w_amt_addr [0:N_PACKETS-1];

  // Lanes past the end of the map repeat the last entry; rewriting it is harmless.
  always_comb begin
    for (int i = 0; i < N_PACKETS; i++) begin
      w_sum[i] = r_base + BW'(i);
      if (r_state != READ)
        w_amt_addr[i] = '0;
      else if (w_sum[i] > LAST)
        w_amt_addr[i] = LAST[INDEX-1:0];
      else
        w_amt_addr[i] = w_sum[i][INDEX-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_base    <= '0;
      r_pkt_cnt <= '0;
      r_flag    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int i = 0; i < N_PACKETS; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // Every READ cycle yields exactly one packet, including the one cut short by a restart.
      r_flag <= (r_state == READ);
      r_done <= 1'b0;
      if (r_state == READ) begin
        for (int i = 0; i < N_PACKETS; i++) begin
          r_addr[i] <= w_amt_addr[i];
          r_data[i] <= amtData_i[i];
        end
      end
      case (r_state)
        IDLE: begin
          if (recoverFlag_i) begin
            r_state   <= READ;
            r_base    <= '0;
            r_pkt_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        READ: begin
          r_busy <= 1'b1;
          if (recoverFlag_i) begin
            r_base    <= '0;
            r_pkt_cnt <= '0;
          end else if (r_pkt_cnt == CNT_LAST) begin
            r_state <= DONE;
          end else begin
            r_base    <= r_base + STEP;
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
          end
        end
        DONE: begin
          if (recoverFlag_i) begin
            r_state   <= READ;
            r_base    <= '0;
            r_pkt_cnt <= '0;
            r_busy    <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign amtAddr_o    = w_amt_addr;
  assign repairFlag_o = r_flag;
  assign repairAddr_o = r_addr;
  assign repairData_o = r_data;
  assign repairBusy_o = r_busy;
  assign repairDone_o = r_done;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_repair_packet_gen.sv
// Bench for repair_packet_gen: three configurations (32/8, 34/8, 8/8), packet scoreboards
// fed by the stimulus, and cycle-by-cycle schedules for busy/done/flag.
module tb_repair_packet_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rec32 = 1'b0, rec34 = 1'b0, rec8 = 1'b0;
  int   n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  // ---------------- DUT 0: DEPTH=32 ----------------
  logic [4:0] d32_amt [0:7];
  logic [6:0] d32_adata [0:7];
  logic [4:0] d32_raddr [0:7];
  logic [6:0] d32_rdata [0:7];
  logic d32_flag, d32_busy, d32_done;
  logic [1:0] d32_state;

  repair_packet_gen #(.DEPTH(32), .INDEX(5), .WIDTH(7), .N_PACKETS(8)) u_d32 (
    .clk(clk), .reset(rst), .recoverFlag_i(rec32),
    .amtAddr_o(d32_amt), .amtData_i(d32_adata),
    .repairFlag_o(d32_flag), .repairAddr_o(d32_raddr), .repairData_o(d32_rdata),
    .repairBusy_o(d32_busy), .repairDone_o(d32_done), .dbg_state_o(d32_state));

  // ---------------- DUT 1: DEPTH=34 ----------------
  logic [5:0] d34_amt [0:7];
  logic [6:0] d34_adata [0:7];
  logic [5:0] d34_raddr [0:7];
  logic [6:0] d34_rdata [0:7];
  logic d34_flag, d34_busy, d34_done;
  logic [1:0] d34_state;

  repair_packet_gen #(.DEPTH(34), .INDEX(6), .WIDTH(7), .N_PACKETS(8)) u_d34 (
    .clk(clk), .reset(rst), .recoverFlag_i(rec34),
    .amtAddr_o(d34_amt), .amtData_i(d34_adata),
    .repairFlag_o(d34_flag), .repairAddr_o(d34_raddr), .repairData_o(d34_rdata),
    .repairBusy_o(d34_busy), .repairDone_o(d34_done), .dbg_state_o(d34_state));

  // ---------------- DUT 2: DEPTH=8 ----------------
  logic [2:0] d8_amt [0:7];
  logic [6:0] d8_adata [0:7];
  logic [2:0] d8_raddr [0:7];
  logic [6:0] d8_rdata [0:7];
  logic d8_flag, d8_busy, d8_done;
  logic [1:0] d8_state;

  repair_packet_gen #(.DEPTH(8), .INDEX(3), .WIDTH(7), .N_PACKETS(8)) u_d8 (
    .clk(clk), .reset(rst), .recoverFlag_i(rec8),
    .amtAddr_o(d8_amt), .amtData_i(d8_adata),
    .repairFlag_o(d8_flag), .repairAddr_o(d8_raddr), .repairData_o(d8_rdata),
    .repairBusy_o(d8_busy), .repairDone_o(d8_done), .dbg_state_o(d8_state));

  // Architectural map model: entry k holds tag k+40.
  logic [127:0] act32, act34, act8, amt32, amt34, amt8;
  always_comb begin
    act32 = '0; act34 = '0; act8 = '0; amt32 = '0; amt34 = '0; amt8 = '0;
    for (int i = 0; i < 8; i++) begin
      d32_adata[i] = 7'(32'(d32_amt[i]) + 40);
      d34_adata[i] = 7'(32'(d34_amt[i]) + 40);
      d8_adata[i]  = 7'(32'(d8_amt[i]) + 40);
      act32[i*16 +: 16] = {8'(d32_raddr[i]), 8'(d32_rdata[i])};
      act34[i*16 +: 16] = {8'(d34_raddr[i]), 8'(d34_rdata[i])};
      act8[i*16 +: 16]  = {8'(d8_raddr[i]), 8'(d8_rdata[i])};
      amt32[i*8 +: 8] = 8'(d32_amt[i]);
      amt34[i*8 +: 8] = 8'(d34_amt[i]);
      amt8[i*8 +: 8]  = 8'(d8_amt[i]);
    end
  end

  logic [127:0] q32[$], q34[$], q8[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Unclamped packet: lanes base..base+7, tags = address + 40.
  function automatic logic [127:0] mk(input int base);
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < 8; i++)
      f[i*16 +: 16] = {8'(base + i), 8'(base + i + 40)};
    return f;
  endfunction

  function automatic logic [127:0] mk_amt(input int base);
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[i*8 +: 8] = 8'(base + i);
    return f;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && d32_flag) begin
      if (q32.size() == 0) begin
        n_tot++;
        $display("FAIL pkt32_unexpected: got %h expected none (t=%0t)", act32, $time);
      end else chk("pkt32", act32, q32.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && d34_flag) begin
      if (q34.size() == 0) begin
        n_tot++;
        $display("FAIL pkt34_unexpected: got %h expected none (t=%0t)", act34, $time);
      end else chk("pkt34", act34, q34.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && d8_flag) begin
      if (q8.size() == 0) begin
        n_tot++;
        $display("FAIL pkt8_unexpected: got %h expected none (t=%0t)", act8, $time);
      end else chk("pkt8", act8, q8.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [2:0] sig(input int sel);
    case (sel)
      0: return {d32_busy, d32_done, d32_flag};
      1: return {d34_busy, d34_done, d34_flag};
      default: return {d8_busy, d8_done, d8_flag};
    endcase
  endfunction

  // Called at a negedge; returns at the negedge inside cycle 1.
  task automatic pulse(input int sel);
    case (sel)
      0: rec32 = 1'b1;
      1: rec34 = 1'b1;
      default: rec8 = 1'b1;
    endcase
    @(negedge clk);
    rec32 = 1'b0; rec34 = 1'b0; rec8 = 1'b0;
  endtask

  // Checks cycles 1..ncyc against bit masks; optionally re-requests recovery in restart_c.
  task automatic run_sched(input string name, input int sel, input int ncyc,
                           input logic [15:0] bm, input logic [15:0] dm,
                           input logic [15:0] fm, input int restart_c);
    logic [2:0] s;
    for (int c = 1; c <= ncyc; c++) begin
      s = sig(sel);
      chk($sformatf("%s_busy_c%0d", name, c), 128'(s[2]), 128'(bm[c]));
      chk($sformatf("%s_done_c%0d", name, c), 128'(s[1]), 128'(dm[c]));
      chk($sformatf("%s_flag_c%0d", name, c), 128'(s[0]), 128'(fm[c]));
      if (sel == 0) rec32 = (c == restart_c);
      @(negedge clk);
    end
    rec32 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] last34;
  logic         bad;

  initial begin
    #1;
    chk("rst_flag", 128'(d32_flag), 128'd0);
    chk("rst_busy", 128'(d32_busy), 128'd0);
    chk("rst_done", 128'(d32_done), 128'd0);
    chk("rst_repair", act32, 128'd0);
    chk("rst_amt", amt32, 128'd0);
    chk("rst_state", 128'(d32_state), 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Quiet idle: no request for 100 cycles.
    bad = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (d32_flag || d32_busy || d32_done || amt32 != 128'd0) bad = 1'b1;
    end
    chk("idle_quiet", 128'(bad), 128'd0);

    // Basic 4-packet recovery.
    q32.push_back(mk(0)); q32.push_back(mk(8));
    q32.push_back(mk(16)); q32.push_back(mk(24));
    pulse(0);
    chk("a_amt_c1", amt32, mk_amt(0));
    chk("a_state_c1", 128'(d32_state), 128'd1);
    run_sched("a", 0, 8, 16'h003E, 16'h0040, 16'h003C, 0);
    chk("a_hold_repair", act32, mk(24));
    chk("a_amt_idle", amt32, 128'd0);

    // Restart sampled at the end of cycle 3: cycle-3 packet (16..23) still issues.
    q32.push_back(mk(0)); q32.push_back(mk(8)); q32.push_back(mk(16));
    q32.push_back(mk(0)); q32.push_back(mk(8)); q32.push_back(mk(16));
    q32.push_back(mk(24));
    pulse(0);
    run_sched("r", 0, 11, 16'h01FE, 16'h0200, 16'h01FC, 3);

    // Asynchronous reset in cycle 3 of a recovery.
    q32.push_back(mk(0)); q32.push_back(mk(8));
    pulse(0);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("ar_flag", 128'(d32_flag), 128'd0);
    chk("ar_busy", 128'(d32_busy), 128'd0);
    chk("ar_done", 128'(d32_done), 128'd0);
    chk("ar_repair", act32, 128'd0);
    chk("ar_amt", amt32, 128'd0);
    bad = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (d32_done || d32_flag || d32_busy) bad = 1'b1;
    end
    chk("ar_quiet", 128'(bad), 128'd0);
    rst = 1'b0;
    q32.push_back(mk(0)); q32.push_back(mk(8));
    q32.push_back(mk(16)); q32.push_back(mk(24));
    pulse(0);
    run_sched("ar_after", 0, 8, 16'h003E, 16'h0040, 16'h003C, 0);

    // DEPTH=34: five packets, last one clamps to entry 33.
    last34 = '0;
    last34[15:0] = {8'd32, 8'd72};
    for (int i = 1; i < 8; i++) last34[i*16 +: 16] = {8'd33, 8'd73};
    q34.push_back(mk(0)); q34.push_back(mk(8)); q34.push_back(mk(16));
    q34.push_back(mk(24)); q34.push_back(last34);
    pulse(1);
    chk("d34_amt_c1", amt34, mk_amt(0));
    run_sched("d34", 1, 9, 16'h007E, 16'h0080, 16'h007C, 0);

    // DEPTH=8: a single packet.
    q8.push_back(mk(0));
    pulse(2);
    chk("d8_amt_c1", amt8, mk_amt(0));
    run_sched("d8", 2, 5, 16'h0006, 16'h0008, 16'h0004, 0);

    repeat (2) @(negedge clk);
    chk("q32_empty", 128'(q32.size()), 128'd0);
    chk("q34_empty", 128'(q34.size()), 128'd0);
    chk("q8_empty", 128'(q8.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
